// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Pipelined RISC-V immediate generator. It decodes a raw 32-bit instruction
// word into an XLEN-wide immediate, a format code and an illegal-opcode flag.
// A valid/ready handshake is backed by an output register (OR) and one skid
// register (SR), so in_ready comes only from registered state and never from
// out_ready. A saturating counter records every illegal instruction that is
// delivered downstream.
//
// Parameters
//   XLEN   immediate width, 32 or 64
//   CNT_W  width of the illegal-instruction counter
//
// Ports
//   clk, rst       clock; synchronous active-high reset
//   flush          drops every buffered entry at the next edge
//   in_valid/in_ready/in_instr      upstream handshake and instruction word
//   out_valid/out_ready             downstream handshake
//   out_imm        extended immediate
//   out_fmt        0=none 1=I 2=S 3=B 4=U 5=J 6=SHAMT 7=ZIMM
//   out_illegal    opcode not recognised
//   illegal_cnt    illegal instructions delivered, saturating
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ZIMM  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
  } entry_t;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  entry_t      dec;
  logic [31:0] imm32;   // signed-format immediate before extension
  logic [5:0]  zimm;    // shamt / CSR zimm, zero-extended
  logic        sext;    // select sign-extended imm32 over zimm
  logic [5:0]  shamt;

  // RV32 has a 5-bit shift amount; RV64 widens it with instr[25].
  assign shamt = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave it unassigned; otherwise synthesis would infer a latch.
    imm32       = '0;
    zimm        = '0;
    sext        = 1'b0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;

    unique case (in_instr[6:0])
      OPC_OP_IMM: begin
        // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount.
        if (in_instr[13:12] == 2'b01) begin
          dec.fmt = FMT_SHAMT;
          zimm    = shamt;
        end else begin
          dec.fmt = FMT_I;
          sext    = 1'b1;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec.fmt = FMT_I;
        sext    = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        sext    = 1'b1;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        sext    = 1'b1;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt = FMT_U;
        sext    = 1'b1;
        imm32   = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        sext    = 1'b1;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      OPC_SYSTEM: begin
        // funct3[2] set marks the CSR immediate forms (CSRRWI/SI/CI).
        if (in_instr[14]) begin
          dec.fmt = FMT_ZIMM;
          zimm    = {1'b0, in_instr[19:15]};
        end else begin
          dec.fmt = FMT_I;
          sext    = 1'b1;
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        end
      end
      default: dec.illegal = 1'b1;
    endcase

    dec.imm = sext ? XLEN'($signed(imm32)) : XLEN'(zimm);
  end

  // ---------------------------------------------------------------------------
  // Handshake and storage
  // ---------------------------------------------------------------------------
  logic   or_valid;
  entry_t or_entry;
  logic   sr_valid;
  entry_t sr_entry;
  logic   accept;
  logic   deliver;
  logic   or_load;

  assign in_ready = !sr_valid && !rst;
  assign accept   = in_valid && in_ready;
  assign deliver  = or_valid && out_ready;
  // OR takes a new entry whenever it is empty or its current entry leaves.
  assign or_load  = !or_valid || deliver;

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      or_valid    <= 1'b0;
      or_entry    <= '0;
      sr_valid    <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      // A deliver in the flush cycle still counts.
      if (deliver && or_entry.illegal && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);

      if (flush) begin
        or_valid <= 1'b0;
        sr_valid <= 1'b0;
      end else if (or_load) begin
        if (sr_valid) begin
          // in_ready is low while SR is full, so no accept competes here.
          or_entry <= sr_entry;
          or_valid <= 1'b1;
          sr_valid <= 1'b0;
        end else if (accept) begin
          or_entry <= dec;
          or_valid <= 1'b1;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (accept) begin
        sr_valid <= 1'b1;
      end
    end
  end

  // NOTE: the skid payload carries no reset; sr_valid alone qualifies it, so
  // resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (!or_load && accept)
      sr_entry <= dec;
  end

  assign out_valid   = or_valid;
  assign out_imm     = or_entry.imm;
  assign out_fmt     = or_entry.fmt;
  assign out_illegal = or_entry.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_pipe
//
// Directed bench for imm_gen_pipe. Three instances share all inputs:
//   dut_a  XLEN=32, CNT_W=16
//   dut_b  XLEN=64, CNT_W=16
//   dut_c  XLEN=32, CNT_W=2   (counter saturation)
// Inputs change 1 time unit after the rising edge; outputs are compared there.
// -----------------------------------------------------------------------------
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        rdy_a, val_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [15:0] cnt_a;

  logic        rdy_b, val_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [15:0] cnt_b;

  logic        rdy_c, val_c, ill_c;
  logic [31:0] imm_c;
  logic [2:0]  fmt_c;
  logic [1:0]  cnt_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy_a), .in_instr(in_instr),
    .out_valid(val_a), .out_ready(out_ready), .out_imm(imm_a),
    .out_fmt(fmt_a), .out_illegal(ill_a), .illegal_cnt(cnt_a)
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy_b), .in_instr(in_instr),
    .out_valid(val_b), .out_ready(out_ready), .out_imm(imm_b),
    .out_fmt(fmt_b), .out_illegal(ill_b), .illegal_cnt(cnt_b)
  );

  imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy_c), .in_instr(in_instr),
    .out_valid(val_c), .out_ready(out_ready), .out_imm(imm_c),
    .out_fmt(fmt_c), .out_illegal(ill_c), .illegal_cnt(cnt_c)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr);
    in_valid = 1'b1;
    in_instr = instr;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    out_ready = 1'b1;
    tick();
    tick();

    // ---- reset state ----
    check("rst_ready_a", 64'(rdy_a), 64'd0);
    check("rst_valid_a", 64'(val_a), 64'd0);
    check("rst_imm_a",   64'(imm_a), 64'd0);
    check("rst_fmt_a",   64'(fmt_a), 64'd0);
    check("rst_ill_a",   64'(ill_a), 64'd0);
    check("rst_cnt_a",   64'(cnt_a), 64'd0);
    check("rst_ready_b", 64'(rdy_b), 64'd0);
    check("rst_valid_b", 64'(val_b), 64'd0);
    check("rst_imm_b",   imm_b,      64'd0);
    check("rst_ill_b",   64'(ill_b), 64'd0);
    check("rst_cnt_b",   64'(cnt_b), 64'd0);
    check("rst_valid_c", 64'(val_c), 64'd0);
    check("rst_ready_c", 64'(rdy_c), 64'd0);
    check("rst_imm_c",   64'(imm_c), 64'd0);
    check("rst_fmt_c",   64'(fmt_c), 64'd0);
    check("rst_ill_c",   64'(ill_c), 64'd0);
    check("rst_cnt_c",   64'(cnt_c), 64'd0);

    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(rdy_a), 64'd1);

    // ---- decode, streaming with out_ready=1 ----
    push(32'hFFF00093);                         // addi x1,x0,-1
    check("addi_valid", 64'(val_a), 64'd1);
    check("addi_imm",   64'(imm_a), 64'hFFFF_FFFF);
    check("addi_fmt",   64'(fmt_a), 64'd1);
    check("addi_ill",   64'(ill_a), 64'd0);
    check("addi_imm64", imm_b,      64'hFFFF_FFFF_FFFF_FFFF);

    push(32'hFE000EE3);                         // beq x0,x0,-4
    check("beq_imm", 64'(imm_a), 64'hFFFF_FFFC);
    check("beq_fmt", 64'(fmt_a), 64'd3);

    push(32'h4030D093);                         // srai x1,x1,3
    check("srai_imm",   64'(imm_a), 64'd3);
    check("srai_fmt",   64'(fmt_a), 64'd6);
    check("srai_imm64", imm_b,      64'd3);

    push(32'h0200D093);                         // srli by 32: instr[25] set
    check("shamt6_imm32", 64'(imm_a), 64'd0);
    check("shamt6_imm64", imm_b,      64'd32);
    check("shamt6_fmt64", 64'(fmt_b), 64'd6);

    push(32'h3002D073);                         // csrrwi, zimm=5
    check("csrrwi_imm", 64'(imm_a), 64'd5);
    check("csrrwi_fmt", 64'(fmt_a), 64'd7);

    push(32'h123450B7);                         // lui positive
    check("lui_pos_imm64", imm_b,      64'h0000_0000_1234_5000);
    check("lui_pos_fmt64", 64'(fmt_b), 64'd4);

    push(32'h800000B7);                         // lui negative
    check("lui_neg_imm64", imm_b,      64'hFFFF_FFFF_8000_0000);
    check("lui_neg_imm32", 64'(imm_a), 64'h8000_0000);
    check("lui_neg_fmt",   64'(fmt_a), 64'd4);

    push(32'hFE112C23);                         // sw x1,-8(x2)
    check("sw_imm", 64'(imm_a), 64'hFFFF_FFF8);
    check("sw_fmt", 64'(fmt_a), 64'd2);

    push(32'hFFDFF06F);                         // jal x0,-4
    check("jal_imm", 64'(imm_a), 64'hFFFF_FFFC);
    check("jal_fmt", 64'(fmt_a), 64'd5);

    push(32'h00000073);                         // ecall: SYSTEM, funct3=0
    check("ecall_imm", 64'(imm_a), 64'd0);
    check("ecall_fmt", 64'(fmt_a), 64'd1);
    check("ecall_ill", 64'(ill_a), 64'd0);

    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(val_a), 64'd0);

    // ---- back-pressure: A, B, C with out_ready low ----
    out_ready = 1'b0;
    push(32'h00500093);                         // A: imm 5
    check("stall_a_valid", 64'(val_a), 64'd1);
    check("stall_a_imm",   64'(imm_a), 64'd5);
    check("stall_a_ready", 64'(rdy_a), 64'd1);
    push(32'h00600093);                         // B: imm 6, goes to skid
    check("stall_b_ready", 64'(rdy_a), 64'd0);
    check("stall_b_imm",   64'(imm_a), 64'd5);
    push(32'h00700093);                         // C: held upstream
    check("stall_c_imm",   64'(imm_a), 64'd5);
    check("stall_c_fmt",   64'(fmt_a), 64'd1);
    check("stall_c_ready", 64'(rdy_a), 64'd0);
    out_ready = 1'b1;
    tick();                                     // A delivered, B to OR
    check("order_b_imm",   64'(imm_a), 64'd6);
    check("order_b_valid", 64'(val_a), 64'd1);
    check("order_b_ready", 64'(rdy_a), 64'd1);
    tick();                                     // B delivered, C accepted
    check("order_c_imm",   64'(imm_a), 64'd7);
    in_valid = 1'b0;
    tick();
    check("order_empty", 64'(val_a), 64'd0);

    // ---- illegal opcode and counter saturation ----
    push(32'h0000007F);
    check("ill_flag", 64'(ill_a), 64'd1);
    check("ill_fmt",  64'(fmt_a), 64'd0);
    check("ill_imm",  64'(imm_a), 64'd0);
    check("ill_imm64", imm_b,     64'd0);
    check("ill_cnt0", 64'(cnt_a), 64'd0);
    push(32'h0000007F);
    push(32'h0000007F);
    in_valid = 1'b0;
    tick();
    check("ill_cnt3_a", 64'(cnt_a), 64'd3);
    check("ill_cnt3_c", 64'(cnt_c), 64'd3);
    push(32'h0000007F);
    push(32'h0000007F);
    in_valid = 1'b0;
    tick();
    check("ill_cnt5_a",  64'(cnt_a), 64'd5);
    check("ill_sat_c",   64'(cnt_c), 64'd3);

    // ---- flush with OR and SR full and in_valid high ----
    out_ready = 1'b0;
    push(32'h00500093);
    push(32'h00600093);
    check("pre_flush_ready", 64'(rdy_a), 64'd0);
    check("pre_flush_valid", 64'(val_a), 64'd1);
    in_instr = 32'h00700093;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 64'(val_a), 64'd0);
    check("flush_ready", 64'(rdy_a), 64'd1);
    out_ready = 1'b1;
    tick();
    check("flush_no_resurrect1", 64'(val_a), 64'd0);
    tick();
    check("flush_no_resurrect2", 64'(val_a), 64'd0);
    check("flush_cnt_kept",      64'(cnt_a), 64'd5);

    // ---- reset mid-stream ----
    out_ready = 1'b0;
    push(32'h0000007F);
    check("pre_rst_valid", 64'(val_a), 64'd1);
    check("pre_rst_ill",   64'(ill_a), 64'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 64'(rdy_a), 64'd0);
    tick();
    check("rst_mid_valid", 64'(val_a), 64'd0);
    check("rst_mid_imm",   64'(imm_a), 64'd0);
    check("rst_mid_fmt",   64'(fmt_a), 64'd0);
    check("rst_mid_ill",   64'(ill_a), 64'd0);
    check("rst_mid_cnt",   64'(cnt_a), 64'd0);
    check("rst_mid_cnt_c", 64'(cnt_c), 64'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_mid_release_ready", 64'(rdy_a), 64'd1);
    tick();
    check("rst_mid_stays_empty", 64'(val_a), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
